bitwise_logic_unit: RTL and testbench

Parametrised, multi-cycle bitwise logic unit for the processor's ALU datapath. It replaces the fixed 32-bit single-function AND/OR blocks with one unit supporting eight logic operations, selected by an opcode. The unit processes operands in SLICE-bit chunks over WIDTH/SLICE cycles, using a start/result-ready handshake like the other multi-cycle ALU units. Each result carries a zero flag.

---
 rtl/bitwise_logic_unit.sv | 162 ++++++++++++++++
 tb/tb_bitwise_logic_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR/NAND/XNOR/ANDN/PASS over SLICE-bit chunks.
// Latency WIDTH/SLICE cycles after the start edge; result_rdy pulses for one cycle with out.
// No backpressure: start is sampled only in IDLE and ignored while busy. Optional popcount via BITWISE_POPCOUNT_EN.
module bitwise_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 ctrl_op,
  input  logic [WIDTH-1:0]           in_0,
  input  logic [WIDTH-1:0]           in_1,
  output logic [WIDTH-1:0]           out,
  output logic                       result_rdy,
  output logic                       busy,
  output logic                       out_zero
`ifdef BITWISE_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcount
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int PW     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_full;
  logic [SLICE-1:0]   slice_a;
  logic [SLICE-1:0]   slice_b;
  logic [SLICE-1:0]   slice_res;
  logic               accept;
  logic               last_slice;

  // One slice of the selected logic function; every opcode is defined.
  function automatic logic [SLICE-1:0] slice_op(input logic [2:0] op,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      default: r = a;
    endcase
    return r;
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start launches a run, last slice returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded control: busy, accept of a new request, final-slice strobe.
  always_comb begin
    busy       = (state == RUN);
    accept     = (state == IDLE) && start;
    last_slice = (state == RUN) && (cnt == LAST);
  end

  // Current slice operands, result, and the accumulator with that slice merged in.
  always_comb begin
    slice_a   = a_q[int'(cnt)*SLICE +: SLICE];
    slice_b   = b_q[int'(cnt)*SLICE +: SLICE];
    slice_res = slice_op(op_q, slice_a, slice_b);
    acc_full  = acc;
    acc_full[int'(cnt)*SLICE +: SLICE] = slice_res;
  end

  // Operand latch, slice counter and partial-result accumulator.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      cnt  <= '0;
      acc  <= '0;
    end else if (accept) begin
      a_q  <= in_0;
      b_q  <= in_1;
      op_q <= ctrl_op;
      cnt  <= '0;
      acc  <= '0;
    end else if (state == RUN) begin
      acc <= acc_full;
      cnt <= last_slice ? '0 : cnt + 1'b1;
    end
  end

  // Visible outputs change only when a full result completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      out        <= '0;
      out_zero   <= 1'b1;
      result_rdy <= 1'b0;
    end else begin
      result_rdy <= last_slice;
      if (last_slice) begin
        out      <= acc_full;
        out_zero <= (acc_full == '0);
      end
    end
  end

`ifdef BITWISE_POPCOUNT_EN
  logic [PW-1:0] pc_acc;
  logic [PW-1:0] pc_slice;

  // Ones in the slice being produced this cycle.
  always_comb begin
    pc_slice = '0;
    for (int i = 0; i < SLICE; i++) pc_slice = pc_slice + PW'(slice_res[i]);
  end

  // Running popcount accumulates per slice and lands with out.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_acc   <= '0;
      popcount <= '0;
    end else if (accept) begin
      pc_acc <= '0;
    end else if (state == RUN) begin
      pc_acc <= last_slice ? '0 : pc_acc + pc_slice;
      if (last_slice) popcount <= pc_acc + pc_slice;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed test of bitwise_logic_unit with SLICE=8 and SLICE=32 instances.
// Expected values are hand-computed constants.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_bitwise_logic_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start32;
  logic [2:0]  ctrl_op;
  logic [31:0] in_0, in_1;
  logic [31:0] out8, out32;
  logic        rdy8, rdy32, busy8, busy32, zero8, zero32;
`ifdef BITWISE_POPCOUNT_EN
  logic [5:0]  pc8, pc32;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut8 (
    .clock(clk), .reset(reset), .start(start8), .ctrl_op(ctrl_op),
    .in_0(in_0), .in_1(in_1), .out(out8), .result_rdy(rdy8),
    .busy(busy8), .out_zero(zero8)
`ifdef BITWISE_POPCOUNT_EN
    , .popcount(pc8)
`endif
  );

  bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) u_dut32 (
    .clock(clk), .reset(reset), .start(start32), .ctrl_op(ctrl_op),
    .in_0(in_0), .in_1(in_1), .out(out32), .result_rdy(rdy32),
    .busy(busy32), .out_zero(zero32)
`ifdef BITWISE_POPCOUNT_EN
    , .popcount(pc32)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (from a falling edge) until result_rdy, counting cycles and busy cycles.
  task automatic wait_done(input int sel, output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (((sel == 32) ? rdy32 : rdy8) !== 1'b1 && cyc < 20) begin
      if ((sel == 32) ? busy32 : busy8) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) chk("timeout", 64'(cyc), 64'(0));
  endtask

  // Issue one request from a falling edge and wait for its result.
  task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cyc, output int bcnt);
    ctrl_op = op; in_0 = a; in_1 = b;
    if (sel == 32) start32 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    wait_done(sel, cyc, bcnt);
  endtask

  int cyc, bcnt, pulses;

  initial begin
    reset = 1'b1; start8 = 1'b0; start32 = 1'b0;
    ctrl_op = 3'd0; in_0 = '0; in_1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_out",  64'(out8), 64'(0));
    chk("rst_zero", 64'(zero8), 64'(1));
    chk("rst_busy", 64'(busy8), 64'(0));
    chk("rst_rdy",  64'(rdy8), 64'(0));
    chk("rst_out32", 64'(out32), 64'(0));
    chk("rst_zero32", 64'(zero32), 64'(1));

    // Test 1
    run_op(8, 3'b001, 32'd1646, 32'd5184, cyc, bcnt);
    chk("t1_or", 64'(out8), 64'(5742));
    chk("t1_lat", 64'(cyc), 64'(4));
    chk("t1_busy", 64'(bcnt), 64'(4));
    chk("t1_zero", 64'(zero8), 64'(0));
    @(negedge clk);
    chk("t1_pulse", 64'(rdy8), 64'(0));
    chk("t1_hold", 64'(out8), 64'(5742));
    run_op(8, 3'b000, 32'd1646, 32'd5184, cyc, bcnt);
    chk("t1_and", 64'(out8), 64'(1088));
`ifdef BITWISE_POPCOUNT_EN
    chk("t1_pc", 64'(pc8), 64'(2));
`endif
    run_op(8, 3'b010, 32'd1646, 32'd5184, cyc, bcnt);
    chk("t1_xor", 64'(out8), 64'(4654));

    // Test 2
    run_op(8, 3'b011, 32'd1646, 32'd5184, cyc, bcnt);
    chk("t2_nor", 64'(out8), 64'(32'hFFFFE991));
    chk("t2_zero", 64'(zero8), 64'(0));
    run_op(8, 3'b000, 32'd783424, 32'd8472456, cyc, bcnt);
    chk("t2_and", 64'(out8), 64'(82944));
    run_op(8, 3'b001, 32'd783424, 32'd8472456, cyc, bcnt);
    chk("t2_or", 64'(out8), 64'(9172936));
    run_op(8, 3'b100, 32'h0000FFFF, 32'h00FF00FF, cyc, bcnt);
    chk("t2_nand", 64'(out8), 64'(32'hFFFFFF00));
    run_op(8, 3'b101, 32'h0000FFFF, 32'h00FF00FF, cyc, bcnt);
    chk("t2_xnor", 64'(out8), 64'(32'hFF0000FF));
    run_op(8, 3'b111, 32'h12345678, 32'hFFFFFFFF, cyc, bcnt);
    chk("t2_pass", 64'(out8), 64'(32'h12345678));

    // Test 3
    run_op(32, 3'b001, 32'd267482, 32'd817648, cyc, bcnt);
    chk("t3_or", 64'(out32), 64'(818682));
    chk("t3_lat", 64'(cyc), 64'(1));
    run_op(32, 3'b000, 32'd267482, 32'd817648, cyc, bcnt);
    chk("t3_and", 64'(out32), 64'(266448));

    // Test 4: zero flag, then back-to-back start on the result_rdy cycle
    run_op(8, 3'b110, 32'hA5A5A5A5, 32'hA5A5A5A5, cyc, bcnt);
    chk("t4_andn", 64'(out8), 64'(0));
    chk("t4_zero", 64'(zero8), 64'(1));
    run_op(8, 3'b010, 32'd1646, 32'd5184, cyc, bcnt);
    chk("t4_b2b", 64'(out8), 64'(4654));
    chk("t4_b2b_lat", 64'(cyc), 64'(4));
    chk("t4_b2b_zero", 64'(zero8), 64'(0));

    // Test 5: reset two cycles after start
    @(negedge clk);
    ctrl_op = 3'b001; in_0 = 32'd1646; in_1 = 32'd5184; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_out", 64'(out8), 64'(0));
    chk("t5_zero", 64'(zero8), 64'(1));
    chk("t5_busy", 64'(busy8), 64'(0));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rdy8) pulses++;
      @(negedge clk);
    end
    chk("t5_no_rdy", 64'(pulses), 64'(0));
    run_op(8, 3'b000, 32'd783424, 32'd8472456, cyc, bcnt);
    chk("t5_after", 64'(out8), 64'(82944));

    // Test 6: start and operand changes during RUN are ignored
    @(negedge clk);
    ctrl_op = 3'b001; in_0 = 32'd783424; in_1 = 32'd8472456; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    ctrl_op = 3'b010; in_0 = 32'hDEADBEEF; in_1 = 32'h0F0F0F0F; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(8, cyc, bcnt);
    chk("t6_result", 64'(out8), 64'(9172936));
    chk("t6_lat", 64'(cyc), 64'(2));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdy8 || busy8) pulses++;
    end
    chk("t6_no_extra", 64'(pulses), 64'(0));
    chk("t6_hold", 64'(out8), 64'(9172936));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
